// File: rtl/bus_mem_responder_if.sv
// Bus between an initiator and the memory responder.
// addr_err exists only when BUS_MEM_ERR_EN is defined.
interface bus_mem_responder_if;
  logic        start_transaction;
  logic        mode;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        rdata_valid;
  logic        write_done;
  logic        busy;
`ifdef BUS_MEM_ERR_EN
  logic        addr_err;
`endif

  modport master (
    output start_transaction, mode, addr, wdata,
`ifdef BUS_MEM_ERR_EN
    input  addr_err,
`endif
    input  rdata, rdata_valid, write_done, busy
  );

  modport slave (
    input  start_transaction, mode, addr, wdata,
`ifdef BUS_MEM_ERR_EN
    output addr_err,
`endif
    output rdata, rdata_valid, write_done, busy
  );
endinterface

// File: rtl/bus_mem_responder.sv
// Single-port word memory behind a strobe bus; BUS_MEM_ERR_EN adds address checking.
// Latency: response pulse WAIT_CYCLES+1 cycles after accept.
// Backpressure: one transaction at a time; starts are dropped while busy.
module bus_mem_responder #(
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  bus_mem_responder_if.slave bus
);
  localparam int         DEPTH        = 1 << DEPTH_LOG2;
  localparam logic [3:0] LP_WAIT_LAST = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t                r_state;
  logic [3:0]            r_cnt;
  logic                  r_mode;
  logic [DEPTH_LOG2-1:0] r_idx;
  logic [31:0]           r_wdata;
  logic [31:0]           r_mem [DEPTH];
  logic [31:0]           r_rdata;
  logic                  r_rdata_valid;
  logic                  r_write_done;
  logic                  r_busy;

  logic                  w_accept;
  logic                  w_fire;
  logic                  w_rsp_mode;
  logic [DEPTH_LOG2-1:0] w_rsp_idx;
  logic                  w_rsp_err;
  logic                  w_lat_err;

  assign w_accept = (r_state == S_IDLE) && bus.start_transaction;

  // With zero wait states the response is launched from the accept edge itself,
  // so the response path must look at the live bus instead of the latched copy.
  assign w_fire     = (w_accept && (WAIT_CYCLES == 0)) ||
                      ((r_state == S_WAIT) && (r_cnt == LP_WAIT_LAST));
  assign w_rsp_mode = (r_state == S_IDLE) ? bus.mode : r_mode;
  assign w_rsp_idx  = (r_state == S_IDLE) ? bus.addr[DEPTH_LOG2+1:2] : r_idx;

`ifdef BUS_MEM_ERR_EN
  logic r_err;
  logic r_addr_err;
  logic w_err_in;

  assign w_err_in  = (bus.addr[1:0] != 2'b00) || (|bus.addr[31:DEPTH_LOG2+2]);
  assign w_rsp_err = (r_state == S_IDLE) ? w_err_in : r_err;
  assign w_lat_err = r_err;
  assign bus.addr_err = r_addr_err;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err      <= 1'b0;
      r_addr_err <= 1'b0;
    end else begin
      if (w_accept) r_err <= w_err_in;
      r_addr_err <= w_fire && w_rsp_err;
    end
  end
`else
  logic w_unused;

  assign w_unused  = ^{bus.addr[31:DEPTH_LOG2+2], bus.addr[1:0]};
  assign w_rsp_err = 1'b0;
  assign w_lat_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_cnt         <= 4'd0;
      r_mode        <= 1'b0;
      r_idx         <= '0;
      r_wdata       <= 32'd0;
      r_rdata       <= 32'd0;
      r_rdata_valid <= 1'b0;
      r_write_done  <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_rdata_valid <= 1'b0;
      r_write_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start_transaction) begin
            r_mode  <= bus.mode;
            r_idx   <= bus.addr[DEPTH_LOG2+1:2];
            r_wdata <= bus.wdata;
            r_cnt   <= 4'd0;
            r_busy  <= 1'b1;
            r_state <= (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt + 4'd1;
          if (r_cnt == LP_WAIT_LAST) r_state <= S_RESP;
        end
        S_RESP: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase

      // Outputs are registered so the pulse lines up with the RESP state.
      if (w_fire) begin
        r_write_done  <= w_rsp_mode;
        r_rdata_valid <= !w_rsp_mode;
        if (!w_rsp_mode) r_rdata <= w_rsp_err ? 32'd0 : r_mem[w_rsp_idx];
      end
    end
  end

  // Commit happens on the edge that closes RESP, so a reset sampled there aborts it.
  always_ff @(posedge clk) begin
    if (rst_n && (r_state == S_RESP) && r_mode && !w_lat_err) r_mem[r_idx] <= r_wdata;
  end

  assign bus.rdata       = r_rdata;
  assign bus.rdata_valid = r_rdata_valid;
  assign bus.write_done  = r_write_done;
  assign bus.busy        = r_busy;
endmodule

// File: doc/bus_mem_responder.md
BUS_MEM_RESPONDER -- requirements
Module: bus_mem_responder

Interface
REQ-001 Parameter: DEPTH_LOG2, default 8, log2 of memory depth in 32-bit words.
REQ-002 Parameter: WAIT_CYCLES, default 2, wait states inserted between accept and response (0..15).
REQ-003 One clock; reset is synchronous and active-low. Ports are clk and rst_n.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 start_transaction  input  1  request strobe from the bus initiator.
REQ-007 mode  input  1  0 = read, 1 = write; sampled with start_transaction.
REQ-008 addr  input  32  byte address; sampled with start_transaction.
REQ-009 wdata  input  32  write data; sampled with start_transaction.
REQ-010 rdata  output  32  read data; valid when rdata_valid = 1.
REQ-011 rdata_valid  output  1  one-cycle pulse completing a read.
REQ-012 write_done  output  1  one-cycle pulse completing a write.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 addr_err  output  1  error flag; present only when BUS_MEM_ERR_EN is defined.

Function
REQ-015 Storage SHALL be 2^DEPTH_LOG2 x 32-bit words, indexed by addr[DEPTH_LOG2+1:2].
REQ-016 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-017 In IDLE with start_transaction = 1, the block SHALL latch mode, addr and wdata.
  - Next state is WAIT if WAIT_CYCLES > 0, else RESP.
REQ-018 WAIT SHALL count WAIT_CYCLES cycles with a 4-bit counter, then enter RESP.
REQ-019 RESP SHALL last exactly one cycle, then return to IDLE.
REQ-020 Write in RESP:
  - Memory is written at the RESP clock edge.
  - write_done = 1 for that single cycle.
REQ-021 Read in RESP:
  - rdata_valid = 1 for that single cycle.
  - rdata = mem[latched index].
REQ-022 rdata SHALL hold its value until the next read response.
REQ-023 Latency: the response pulse SHALL be asserted WAIT_CYCLES+1 cycles after the cycle in which start was sampled.
REQ-024 start_transaction while busy = 1 SHALL be ignored: no latch, no queueing.
REQ-025 start_transaction in the RESP cycle SHALL be ignored; a new request is accepted from the following IDLE cycle.
REQ-026 Inputs mode, addr and wdata need not be held after the accept cycle.
REQ-027 rdata_valid and write_done SHALL never be asserted together.
REQ-028 Without BUS_MEM_ERR_EN, addr[1:0] and addr bits above DEPTH_LOG2+1 SHALL be ignored, so addresses wrap.

Reset
REQ-029 While rst_n = 0 at a clock edge, the block SHALL reset as follows:
  - State goes to IDLE and the counter to 0.
  - rdata = 0; rdata_valid, write_done, busy and addr_err = 0.
REQ-030 Memory contents SHALL NOT be reset.
REQ-031 Reset during WAIT or RESP SHALL abort the transaction.
  - No memory write occurs.
  - No response pulse follows.

Configuration
REQ-032 Macro BUS_MEM_ERR_EN SHALL enable address checking and the addr_err port.
REQ-033 When BUS_MEM_ERR_EN is defined, an address is in error if addr[1:0] != 0 or addr >= 4*2^DEPTH_LOG2.
REQ-034 For an erroneous address:
  - addr_err pulses in the RESP cycle together with rdata_valid or write_done.
  - A write is suppressed.
  - A read returns rdata = 0.
REQ-035 Without BUS_MEM_ERR_EN, addr_err and all checking logic SHALL be absent, and REQ-028 applies.

Verification
REQ-036 Write then read, WAIT_CYCLES = 2:
  - Write addr 0x10, data 0xDEADBEEF -> write_done pulses 3 cycles after start.
  - Read addr 0x10 -> rdata_valid pulses 3 cycles after start with rdata = 0xDEADBEEF.
REQ-037 Back-to-back request: a second start asserted while busy = 1 -> ignored.
  - Exactly one response pulse occurs.
  - Memory is unchanged by the second request.
REQ-038 WAIT_CYCLES = 0: read start at cycle N -> rdata_valid at cycle N+1; a new start at N+2 is accepted.
REQ-039 Reset mid-operation: write start, then rst_n = 0 during WAIT ->
  - No write_done pulse.
  - A subsequent read of that address returns the old data.
  - All outputs are 0 while in reset.
REQ-040 Wrap-around (no macro, DEPTH_LOG2 = 8): write addr 0x400 with 0x1234 -> read addr 0x000 returns 0x1234.
REQ-041 With BUS_MEM_ERR_EN:
  - Write addr 0x402 -> addr_err = 1 together with write_done, and memory is unchanged.
  - Read addr 0x400 -> addr_err = 1 with rdata = 0.
